decoder_pipe: RTL

//  Registered number-to-one-hot decoder; inverse of the bitmap-to-number encoder in macro/com.

---
 rtl/decoder_pipe_pkg.sv | 17 +
 rtl/decoder_pipe_if.sv | 30 +++
 rtl/decoder_skid.sv | 98 +++++++++
 rtl/decoder_pipe.sv | 74 +++++++
 4 files changed

// File: rtl/decoder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// decoder_pipe_pkg : skid-buffer state encoding and default widths
// Rev 1.0
// ============================================================================
package decoder_pipe_pkg;

    localparam int DEF_NUMW = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/decoder_pipe_if.sv
`default_nettype none
// ============================================================================
// decoder_pipe_if : index-in / bitmap-out handshake bundle of decoder_pipe
// Rev 1.0
// ============================================================================
interface decoder_pipe_if #(
    parameter int NUMW = 4,
    parameter int BITW = 2**NUMW
);
    logic            in_vld;
    logic            in_rdy;
    logic [NUMW-1:0] number;
    logic            out_vld;
    logic            out_rdy;
    logic [BITW-1:0] bitmap;
    logic            out_err;
    logic            acc_clr;
    logic [BITW-1:0] acc_map;

    modport master (
        output in_vld, number, out_rdy, acc_clr,
        input  in_rdy, out_vld, bitmap, out_err, acc_map
    );

    modport slave (
        input  in_vld, number, out_rdy, acc_clr,
        output in_rdy, out_vld, bitmap, out_err, acc_map
    );
endinterface
`default_nettype wire

// File: rtl/decoder_skid.sv
`default_nettype none
// ============================================================================
// decoder_skid : 2-entry valid/ready skid buffer (main + skid register)
// Rev 1.0
// ============================================================================
module decoder_skid
    import decoder_pipe_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              in_vld,
    input  wire  [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    input  wire              out_rdy
);
    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_rdy;
    logic             w_accept;
    logic             w_consume;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;

    assign w_accept  = in_vld & r_in_rdy;
    assign w_consume = out_vld & out_rdy;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_consume) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_consume) begin
                    w_load_main = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_consume) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Ready is registered from the next state so it is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_in_rdy <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_rdy   = r_in_rdy;
    assign out_vld  = (r_state != ST_EMPTY);
    assign out_data = out_vld ? r_main : '0;

endmodule
`default_nettype wire

// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
// decoder_pipe : registered index-to-one-hot decoder with skid-buffered output
//   Optional accumulated mask of accepted bitmaps when DECODER_ACC_EN is defined.
// Rev 1.0
// ============================================================================
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter int NUMW = DEF_NUMW,
    parameter int BITW = 2**NUMW
) (
    input  wire           clk,
    input  wire           rst_n,
    decoder_pipe_if.slave bus
);
    // Returns {err, bitmap}; compares at full index width so out-of-range never aliases.
    function automatic logic [BITW:0] onehot_dec(input logic [NUMW-1:0] num);
        logic [BITW-1:0] map;
        map = '0;
        for (int k = 0; k < BITW; k++) begin
            if (32'(num) == 32'(k)) begin
                map[k] = 1'b1;
            end
        end
        return {(32'(num) >= 32'(BITW)), map};
    endfunction

    logic [BITW:0] w_dec;
    logic [BITW:0] w_out;

    assign w_dec = onehot_dec(bus.number);

    decoder_skid #(
        .WIDTH (BITW + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (bus.in_vld),
        .in_data  (w_dec),
        .in_rdy   (bus.in_rdy),
        .out_vld  (bus.out_vld),
        .out_data (w_out),
        .out_rdy  (bus.out_rdy)
    );

    assign bus.bitmap  = w_out[BITW-1:0];
    assign bus.out_err = w_out[BITW];

`ifdef DECODER_ACC_EN
    logic [BITW-1:0] r_acc;
    logic            w_accept;

    assign w_accept = bus.in_vld & bus.in_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (bus.acc_clr) begin
            r_acc <= w_accept ? w_dec[BITW-1:0] : '0;
        end else if (w_accept) begin
            r_acc <= r_acc | w_dec[BITW-1:0];
        end
    end

    assign bus.acc_map = r_acc;
`else
    logic w_unused;
    assign w_unused    = bus.acc_clr;
    assign bus.acc_map = '0;
`endif

endmodule
`default_nettype wire
